text_console: RTL and testbench

TEXT_CONSOLE -- requirements
Module: text_console

---
 rtl/text_console.sv | 171 +++++++++++++++++
 tb/tb_text_console.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_console.sv
// Character-cell text console: clears the screen, prints characters and control codes
// at the cursor, and scrolls the screen up one row when the cursor leaves the last row.
module text_console #(
    parameter int         COLS  = 40,
    parameter int         ROWS  = 25,
    parameter logic [7:0] BLANK = 8'h20
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic [9:0] mem_addr,
    input  logic [7:0] mem_din,
    output logic [7:0] mem_dout,
    output logic       mem_we,
    output logic [5:0] cursor_x,
    output logic [4:0] cursor_y
);

    typedef enum logic [2:0] {
        CLEAR,
        IDLE,
        EXEC,
        SCR_RD,
        SCR_WR,
        SCR_CLR
    } state_t;

    localparam logic [9:0] COLS_W        = 10'(COLS);
    localparam logic [9:0] LAST_CELL     = 10'(COLS * ROWS - 1);
    localparam logic [9:0] LAST_MOVE     = 10'((ROWS - 1) * COLS - 1);
    localparam logic [9:0] LAST_ROW_BASE = 10'((ROWS - 1) * COLS);
    localparam logic [5:0] LAST_COL      = 6'(COLS - 1);
    localparam logic [4:0] LAST_ROW      = 5'(ROWS - 1);

    state_t     state_reg, state_next;
    logic [9:0] idx_reg, idx_next;
    logic [5:0] col_reg, col_next;
    logic [4:0] row_reg, row_next;
    logic [7:0] char_reg, char_next;
    logic       bs_reg, bs_next;
    logic [9:0] cur_addr;

    assign cur_addr = 10'(row_reg) * COLS_W + 10'(col_reg);
    assign cursor_x = col_reg;
    assign cursor_y = row_reg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= CLEAR;
            idx_reg   <= '0;
            col_reg   <= '0;
            row_reg   <= '0;
            char_reg  <= '0;
            bs_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            col_reg   <= col_next;
            row_reg   <= row_next;
            char_reg  <= char_next;
            bs_reg    <= bs_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        col_next   = col_reg;
        row_next   = row_reg;
        char_next  = char_reg;
        bs_next    = bs_reg;
        case (state_reg)
            CLEAR, SCR_CLR: begin
                if (idx_reg == LAST_CELL) begin
                    idx_next   = '0;
                    state_next = IDLE;
                end else begin
                    idx_next = idx_reg + 10'd1;
                end
            end
            IDLE: begin
                if (valid) begin
                    char_next  = data;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                state_next = IDLE;
                if (bs_reg) begin
                    // second backspace cycle: the blank is written by the output logic
                    bs_next = 1'b0;
                end else if (char_reg >= 8'h20 || char_reg == 8'h0A) begin
                    if (char_reg != 8'h0A && col_reg != LAST_COL) begin
                        col_next = col_reg + 6'd1;
                    end else begin
                        col_next = '0;
                        if (row_reg == LAST_ROW) begin
                            idx_next   = '0;
                            state_next = SCR_RD;
                        end else begin
                            row_next = row_reg + 5'd1;
                        end
                    end
                end else if (char_reg == 8'h0D) begin
                    col_next = '0;
                end else if (char_reg == 8'h08 && col_reg != 6'd0) begin
                    col_next   = col_reg - 6'd1;
                    bs_next    = 1'b1;
                    state_next = EXEC;
                end
            end
            SCR_RD: begin
                state_next = SCR_WR;
            end
            SCR_WR: begin
                if (idx_reg == LAST_MOVE) begin
                    idx_next   = LAST_ROW_BASE;
                    state_next = SCR_CLR;
                end else begin
                    idx_next   = idx_reg + 10'd1;
                    state_next = SCR_RD;
                end
            end
            default: begin
                state_next = CLEAR;
                idx_next   = '0;
            end
        endcase
    end

    always_comb begin
        ready    = 1'b0;
        mem_we   = 1'b0;
        mem_addr = cur_addr;
        mem_dout = BLANK;
        case (state_reg)
            CLEAR, SCR_CLR: begin
                mem_we   = 1'b1;
                mem_addr = idx_reg;
            end
            IDLE: begin
                ready = 1'b1;
            end
            EXEC: begin
                mem_we   = bs_reg || (char_reg >= 8'h20);
                mem_dout = bs_reg ? BLANK : char_reg;
            end
            SCR_RD: begin
                mem_addr = idx_reg + COLS_W;
            end
            SCR_WR: begin
                mem_we   = 1'b1;
                mem_addr = idx_reg;
                mem_dout = mem_din;
            end
            default: begin
                ready = 1'b0;
            end
        endcase
        // outputs go quiet for as long as reset is held, not just from the next edge
        if (!reset_n) begin
            ready    = 1'b0;
            mem_we   = 1'b0;
            mem_addr = '0;
            mem_dout = '0;
        end
    end

endmodule

// File: tb/tb_text_console.sv
// Bench for text_console: a screen-array model predicts contents, cursor, busy time and
// write counts per character; a per-cycle process checks cursor and idle outputs.
module tb_text_console;

    localparam int         COLS       = 40;
    localparam int         ROWS       = 25;
    localparam int         CELLS      = COLS * ROWS;
    localparam logic [7:0] BLANK      = 8'h20;
    localparam int         SCROLL_CYC = 2 * (ROWS - 1) * COLS + COLS;

    logic       clock   = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] data    = 8'h00;
    logic       valid   = 1'b0;
    logic       ready;
    logic [9:0] mem_addr;
    logic [7:0] mem_din;
    logic [7:0] mem_dout;
    logic       mem_we;
    logic [5:0] cursor_x;
    logic [4:0] cursor_y;

    text_console #(.COLS(COLS), .ROWS(ROWS), .BLANK(BLANK)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .data     (data),
        .valid    (valid),
        .ready    (ready),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_dout (mem_dout),
        .mem_we   (mem_we),
        .cursor_x (cursor_x),
        .cursor_y (cursor_y)
    );

    always #5 clock = ~clock;

    // character memory with one-cycle registered read
    logic [7:0] mem [0:1023];
    int         wr_count = 0;
    logic [9:0] last_wr_addr;
    logic [7:0] last_wr_data;

    always @(posedge clock) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_dout;
            wr_count      <= wr_count + 1;
            last_wr_addr  <= mem_addr;
            last_wr_data  <= mem_dout;
        end
        mem_din <= mem[mem_addr];
    end

    logic [7:0] ref_scr [0:CELLS-1];
    int m_col = 0;
    int m_row = 0;
    int tests = 0;
    int fails = 0;
    int wr_snap = 0;

    task automatic check(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    task automatic model_blank();
        for (int i = 0; i < CELLS; i++) ref_scr[i] = BLANK;
        m_col = 0;
        m_row = 0;
    endtask

    task automatic model_newline(inout int eb, inout int ew);
        m_col = 0;
        if (m_row == ROWS - 1) begin
            for (int i = 0; i < CELLS - COLS; i++) ref_scr[i] = ref_scr[i + COLS];
            for (int i = CELLS - COLS; i < CELLS; i++) ref_scr[i] = BLANK;
            eb += SCROLL_CYC;
            ew += CELLS;
        end else begin
            m_row++;
        end
    endtask

    task automatic model_apply(input logic [7:0] c, output int eb, output int ew);
        eb = 1;
        ew = 0;
        if (c >= 8'h20) begin
            ref_scr[m_row * COLS + m_col] = c;
            ew = 1;
            m_col++;
            if (m_col == COLS) model_newline(eb, ew);
        end else if (c == 8'h0D) begin
            m_col = 0;
        end else if (c == 8'h0A) begin
            model_newline(eb, ew);
        end else if (c == 8'h08 && m_col > 0) begin
            m_col--;
            ref_scr[m_row * COLS + m_col] = BLANK;
            ew = 1;
            eb = 2;
        end
    endtask

    // every cycle: address range always; cursor and write strobe whenever the block is idle
    always @(negedge clock) begin
        if (reset_n) begin
            check("addr_range", int'(mem_addr < 10'(CELLS)), 1);
            if (ready) begin
                check("cursor_x", int'(cursor_x), m_col);
                check("cursor_y", int'(cursor_y), m_row);
                check("idle_we", int'(mem_we), 0);
            end
        end
    end

    task automatic check_screen(input string name);
        int bad = 0;
        for (int i = 0; i < CELLS; i++) if (mem[i] !== ref_scr[i]) bad++;
        check(name, bad, 0);
    endtask

    // caller sits at a falling edge; hold keeps valid high afterwards with a decoy printable
    task automatic accept(input logic [7:0] c, input bit hold, output int eb, output int ew);
        int n = 0;
        while (!ready && n < 5000) begin
            @(negedge clock);
            n++;
        end
        check("accept_wait", int'(ready), 1);
        valid = 1'b1;
        data  = c;
        @(posedge clock);
        #1;
        valid = hold;
        if (hold) data = 8'h58;
        wr_snap = wr_count;
        model_apply(c, eb, ew);
    endtask

    task automatic finish(input int eb, input int ew);
        int busy = 0;
        @(negedge clock);
        while (!ready && busy < 5000) begin
            busy++;
            @(negedge clock);
        end
        check("busy_cycles", busy, eb);
        check("write_count", wr_count - wr_snap, ew);
        check_screen("screen");
    endtask

    task automatic send(input logic [7:0] c);
        int eb, ew;
        accept(c, 1'b0, eb, ew);
        finish(eb, ew);
    endtask

    task automatic send_held(input logic [7:0] c, input bit hold);
        int eb, ew;
        accept(c, hold, eb, ew);
        finish(eb, ew);
    endtask

    task automatic check_reset_outputs();
        check("rst_ready", int'(ready), 0);
        check("rst_we", int'(mem_we), 0);
        check("rst_addr", int'(mem_addr), 0);
        check("rst_dout", int'(mem_dout), 0);
        check("rst_cx", int'(cursor_x), 0);
        check("rst_cy", int'(cursor_y), 0);
    endtask

    task automatic check_clear();
        int bad = 0;
        for (int i = 0; i < CELLS; i++) begin
            @(negedge clock);
            if (!(mem_we === 1'b1 && int'(mem_addr) == i && mem_dout === BLANK)) bad++;
        end
        @(negedge clock);
        check("clear_writes", bad, 0);
        check("clear_ready", int'(ready), 1);
        check_screen("clear_screen");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int eb, ew;
        model_blank();
        repeat (3) @(posedge clock);
        #1;
        check_reset_outputs();
        @(posedge clock);
        #2;
        reset_n = 1'b1;
        check_clear();

        // first character lands at address 0
        send(8'h41);
        check("a_addr", int'(last_wr_addr), 0);
        check("a_data", int'(last_wr_data), 8'h41);
        check("a_cx", int'(cursor_x), 1);

        // rest of row 0 wraps to row 1
        for (int i = 1; i < COLS; i++) send(8'(8'h61 + i % 26));
        check("wrap_cx", int'(cursor_x), 0);
        check("wrap_cy", int'(cursor_y), 1);
        send(8'h08);
        check("bs0_cx", int'(cursor_x), 0);
        check("bs0_cy", int'(cursor_y), 1);
        send(8'h42);
        send(8'h08);
        check("bs_cell40", int'(mem[40]), 8'h20);
        check("bs_cx", int'(cursor_x), 0);
        check("bs_cy", int'(cursor_y), 1);

        // CR, LF and an ignored control code
        send(8'h61);
        send(8'h62);
        send(8'h07);
        check("bel_cx", int'(cursor_x), 2);
        send(8'h0D);
        check("cr_cx", int'(cursor_x), 0);
        send(8'h0A);
        check("lf_cy", int'(cursor_y), 2);

        // valid held high across three codes
        send(8'h7A);
        send(8'h7A);
        send_held(8'h0D, 1'b1);
        send_held(8'h07, 1'b1);
        send_held(8'h43, 1'b0);
        check("held_c80", int'(mem[80]), 8'h43);
        check("held_c81", int'(mem[81]), 8'h7A);
        check("held_cx", int'(cursor_x), 1);

        // walk down to (5,24) leaving a mark on each row
        for (int r = 2; r < ROWS - 1; r++) begin
            send(8'(8'h30 + r));
            send(8'h0A);
        end
        send(8'h50);
        send(8'h51);
        send(8'h52);
        send(8'h53);
        send(8'h54);
        check("pre_cx", int'(cursor_x), 5);
        check("pre_cy", int'(cursor_y), 24);

        // LF on the last row scrolls
        send(8'h0A);
        check("scr_c0", int'(mem[0]), 8'h61);
        check("scr_c1", int'(mem[1]), 8'h62);
        check("scr_c40", int'(mem[40]), 8'h43);
        check("scr_c41", int'(mem[41]), 8'h32);
        check("scr_c920", int'(mem[920]), 8'h50);
        check("scr_c960", int'(mem[960]), 8'h20);
        check("scr_c999", int'(mem[999]), 8'h20);
        check("scr_cx", int'(cursor_x), 0);
        check("scr_cy", int'(cursor_y), 24);

        // column wrap on the last row also scrolls
        for (int i = 0; i < COLS; i++) send(8'(8'h41 + i % 26));
        check("wscr_c0", int'(mem[0]), 8'h43);
        check("wscr_c920", int'(mem[920]), 8'h41);
        check("wscr_c959", int'(mem[959]), 8'h4E);
        check("wscr_cy", int'(cursor_y), 24);

        // reset in the middle of a scroll
        accept(8'h0A, 1'b0, eb, ew);
        repeat (500) @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs();
        model_blank();
        @(posedge clock);
        #1;
        check_reset_outputs();
        @(posedge clock);
        #2;
        reset_n = 1'b1;
        check_clear();
        send(8'h41);
        check("post_addr", int'(last_wr_addr), 0);
        check("post_data", int'(last_wr_data), 8'h41);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
